conv3x3_stream: RTL and testbench
=================================

# conv3x3_stream

Parametrised 3x3 streaming convolution for the camera pipeline. It is the successor to the fixed edge-only convolution stage. It takes one grayscale pixel per handshake in raster order and buffers two image rows internally. It emits one filtered pixel per valid 3x3 window position. Kernel mode (pass, edge, blur, sharpen) is selectable per frame, and both ports use valid/ready backpressure. It sits between the camera pixel source and the display/threshold stage.

## Interface
- DATA_W, 8: pixel width, unsigned.
- IMG_W, 640: pixels per row, must be ≥ 3.
- IMG_H, 480: rows per frame, must be ≥ 3.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- mode  in  2  kernel select: 0 pass, 1 edge, 2 blur, 3 sharpen. Latched at frame start.
- x_data  in  DATA_W  input pixel.
- x_valid  in  1  input pixel present.
- x_sof  in  1  qualifies x_data as pixel (0,0) of a new frame.
- x_ready  out  1  block accepts input this cycle.
- y_data  out  DATA_W  filtered pixel.
- y_valid  out  1  output pixel present.
- y_ready  in  1  sink accepts output.
- y_last  out  1  marks the final output pixel of a frame.

## Operation
- Accept means `x_valid && x_ready`. Transfer means `y_valid && y_ready`.
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance on each accept, raster order.
  - `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 after the last pixel of the frame.
- An accept with `x_sof=1` treats the pixel as (0,0) regardless of counter state. Counters continue from there, so the block resyncs after a broken frame.
- `mode` is sampled into `mode_q` on every accept at (0,0). It is constant for the rest of the frame.
- Two line buffers, each IMG_W × DATA_W, hold rows row-1 and row-2 at column `col`. They are read and written in the same cycle on accept. A 3x3 window register shifts one column left on each accept.
- Output rule: an accept at (r,c) with r ≥ 2 and c ≥ 2 produces the result for centre (r-1,c-1). Border centres are never emitted. One frame yields (IMG_W-2)×(IMG_H-2) outputs.
- Kernels use centre C, 4-neighbours N/S/E/W, diagonals D1..D4, and MAX = 2^DATA_W-1:
  - pass: C.
  - edge: |8C − (N+S+E+W+D1+D2+D3+D4)|, saturated to MAX.
  - blur: (4C + 2(N+S+E+W) + (D1+D2+D3+D4)) >> 4, truncating.
  - sharpen: 5C − (N+S+E+W), clamped to [0, MAX].
- Intermediate arithmetic is signed, DATA_W+5 bits. There is no overflow before the clamp.
- `y_last` is high with the output for centre (IMG_H-2, IMG_W-2).

## Timing
- Reset values: x_ready=1, y_valid=0, y_data=0, y_last=0, col=row=0, mode_q=0.
  - Line-buffer contents are not cleared; the r ≥ 2 gate makes them irrelevant.
- Latency: the result is registered. y_valid rises on the clock edge of the triggering accept and is visible the next cycle.
- Single output register: `x_ready = !y_valid || y_ready`, combinational. There is no throughput loss with y_ready held at 1, so the block runs at 1 pixel/cycle.
- While `y_valid && !y_ready`: y_data, y_valid and y_last hold stable, x_ready=0, and no internal state changes.
- y_valid falls after a transfer unless a new output-producing accept happens in the same cycle. Simultaneous transfer and accept replaces the output register with no gap.
- Reset asserted mid-frame aborts the frame immediately. The next accepted pixel is (0,0).
- A `mode` change mid-frame has no effect until the next (0,0) accept.

## Test plan
The bench uses IMG_W=8, IMG_H=4, DATA_W=8 (12 outputs per frame).
- Constant frame of 100, modes 1/2/3/0 → 12 outputs each: edge 0, blur 100, sharpen 100, pass 100. y_last on output 12 only.
- Frame all 0 except 255 at (1,1), mode edge → first output (centre (1,1)) 255 (saturated from 2040), second (centre (1,2)) 255.
  - Same frame, mode sharpen → 255 then 0 (clamped from −255).
- Ramp frame x=8r+c, mode blur → every output equals the centre value (linear ramp preserved). Compare against a reference model.
- Random y_ready (50% duty) and random x_valid gaps, random frame → output sequence identical to the no-stall run. y_data stays stable while stalled, and x_ready=0 whenever y_valid=1 and y_ready=0.
- mode switched from 2 to 1 at pixel (2,3) → whole frame processed as blur. The next frame is processed as edge.
- Reset asserted at pixel (2,5), then a clean frame → exactly 12 correct outputs, no residue from the aborted frame.
  - Repeat with x_sof asserted mid-frame instead of reset → same result.

Source files
------------

// File: rtl/conv3x3_stream.sv
// ---------------------------------------------------------------------------
// conv3x3_stream
//
// Streaming 3x3 convolution over a raster-ordered grayscale image. Two line
// buffers keep the previous two rows. A two-column window register plus the
// column being accepted form the 3x3 neighbourhood. One filtered pixel is
// produced per interior window position. The kernel (pass / edge / blur /
// sharpen) is latched at the first pixel of each frame.
//
// Parameters
//   DATA_W  pixel width (unsigned)
//   IMG_W   pixels per row  (>= 3)
//   IMG_H   rows per frame  (>= 3)
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset, clears all state
//   mode     in   2-bit kernel select: 0 pass, 1 edge, 2 blur, 3 sharpen
//   x_data   in   input pixel
//   x_valid  in   input pixel present
//   x_sof    in   input pixel is (0,0) of a new frame
//   x_ready  out  block accepts input this cycle
//   y_data   out  filtered pixel
//   y_valid  out  output pixel present
//   y_ready  in   sink accepts output
//   y_last   out  final output pixel of a frame
// ---------------------------------------------------------------------------
module conv3x3_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] x_data,
  input  logic              x_valid,
  input  logic              x_sof,
  output logic              x_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              y_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int ACC_W = DATA_W + 5;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((2 ** DATA_W) - 1);

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_EDGE    = 2'd1,
    MODE_BLUR    = 2'd2,
    MODE_SHARPEN = 2'd3
  } mode_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  mode_e             mode_q, mode_d;
  logic [DATA_W-1:0] y_data_q, y_data_d;
  logic              y_valid_q, y_valid_d;
  logic              y_last_q, y_last_d;

  // Two most recent window columns; row index 0 is the oldest image row.
  logic [DATA_W-1:0] win_q [3][2];
  logic [DATA_W-1:0] win_d [3][2];

  // Line buffers: line1 holds row-1, line2 holds row-2, addressed by column.
  logic [DATA_W-1:0] line1_mem [IMG_W];
  logic [DATA_W-1:0] line2_mem [IMG_W];

  // -------------------------------------------------------------------------
  // Handshake and position decode
  // -------------------------------------------------------------------------
  logic              accept;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic              at_origin;
  logic              emit;
  logic              at_last;

  // A single output register: input may proceed whenever that register is
  // empty or is being drained this cycle.
  assign x_ready = !y_valid_q || y_ready;
  assign accept  = x_valid && x_ready;

  // x_sof overrides the counters so a truncated frame cannot desynchronise us.
  assign cur_col   = x_sof ? '0 : col_q;
  assign cur_row   = x_sof ? '0 : row_q;
  assign at_origin = (cur_col == '0) && (cur_row == '0);

  // Interior centres only: the accepted pixel is the bottom-right corner of
  // the window, so the centre is one row up and one column left.
  assign emit    = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
  assign at_last = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  // -------------------------------------------------------------------------
  // Window assembly
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] col_in [3];
  logic [DATA_W-1:0] wnd    [3][3];

  assign col_in[0] = line2_mem[cur_col];
  assign col_in[1] = line1_mem[cur_col];
  assign col_in[2] = x_data;

  for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
    assign wnd[gi][0]   = win_q[gi][0];
    assign wnd[gi][1]   = win_q[gi][1];
    assign wnd[gi][2]   = col_in[gi];
    assign win_d[gi][0] = accept ? win_q[gi][1] : win_q[gi][0];
    assign win_d[gi][1] = accept ? col_in[gi]   : win_q[gi][1];
  end

  // -------------------------------------------------------------------------
  // Kernel arithmetic
  // -------------------------------------------------------------------------
  function automatic logic signed [ACC_W-1:0] ext(input logic [DATA_W-1:0] p);
    return {{(ACC_W - DATA_W){1'b0}}, p};
  endfunction

  function automatic logic [DATA_W-1:0] clamp_px(input logic signed [ACC_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v[ACC_W-1]) begin
      r = '0;
    end else if (v > PIX_MAX) begin
      r = {DATA_W{1'b1}};
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

  logic signed [ACC_W-1:0] c_s;
  logic signed [ACC_W-1:0] sum_orth;
  logic signed [ACC_W-1:0] sum_diag;
  logic signed [ACC_W-1:0] edge_raw;
  logic signed [ACC_W-1:0] edge_abs;
  logic signed [ACC_W-1:0] blur_raw;
  logic signed [ACC_W-1:0] sharp_raw;
  logic [DATA_W-1:0]       result;

  always_comb begin
    c_s      = ext(wnd[1][1]);
    sum_orth = ext(wnd[0][1]) + ext(wnd[2][1]) + ext(wnd[1][0]) + ext(wnd[1][2]);
    sum_diag = ext(wnd[0][0]) + ext(wnd[0][2]) + ext(wnd[2][0]) + ext(wnd[2][2]);

    edge_raw  = (c_s <<< 3) - sum_orth - sum_diag;
    edge_abs  = edge_raw[ACC_W-1] ? -edge_raw : edge_raw;
    blur_raw  = (c_s <<< 2) + (sum_orth <<< 1) + sum_diag;
    sharp_raw = (c_s <<< 2) + c_s - sum_orth;

    result = wnd[1][1];
    case (mode_q)
      MODE_PASS:    result = wnd[1][1];
      MODE_EDGE:    result = clamp_px(edge_abs);
      // Weights sum to 16, so the shifted value is always within range; the
      // clamp only guards the narrowing.
      MODE_BLUR:    result = clamp_px(blur_raw >>> 4);
      MODE_SHARPEN: result = clamp_px(sharp_raw);
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    mode_d = mode_q;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
      if (at_origin) begin
        mode_d = mode_e'(mode);
      end
    end
  end

  // Loading a new result takes priority over draining: a simultaneous
  // transfer and output-producing accept simply replaces the register.
  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_last_d  = y_last_q;
    if (accept && emit) begin
      y_valid_d = 1'b1;
      y_data_d  = result;
      y_last_d  = at_last;
    end else if (y_ready) begin
      y_valid_d = 1'b0;
      y_last_d  = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      mode_q    <= MODE_PASS;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 2; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      mode_q    <= mode_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 2; j++) begin
          win_q[i][j] <= win_d[i][j];
        end
      end
    end
  end

  // Line buffers are not reset: rows 0 and 1 of every frame rewrite each
  // entry before the row >= 2 gate lets any of it reach the output.
  always_ff @(posedge clk) begin
    if (accept) begin
      line1_mem[cur_col] <= x_data;
      line2_mem[cur_col] <= col_in[1];
    end
  end

  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;
  assign y_last  = y_last_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// ---------------------------------------------------------------------------
// tb_conv3x3_stream
//
// Self-checking bench for conv3x3_stream on an 8x4 image. A table of frame
// patterns/modes is streamed through the block; expected pixels come from a
// direct 3x3 reference model and are queued when each pixel is driven, then
// popped as the block hands results over. Hand-written sequences cover a
// mid-frame mode change and frames aborted by reset or by x_sof.
// ---------------------------------------------------------------------------
module tb_conv3x3_stream;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int NOUT = (W - 2) * (H - 2);
  localparam int NV = 10;

  logic          clk;
  logic          reset;
  logic [1:0]    mode;
  logic [DW-1:0] x_data;
  logic          x_valid;
  logic          x_sof;
  logic          x_ready;
  logic [DW-1:0] y_data;
  logic          y_valid;
  logic          y_ready;
  logic          y_last;

  conv3x3_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .x_data  (x_data),
    .x_valid (x_valid),
    .x_sof   (x_sof),
    .x_ready (x_ready),
    .y_data  (y_data),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_last  (y_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    int       pat;
    bit [1:0] md;
    bit       stall;
    int       exp0;
    int       exp1;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[NV];
  int   frame[H][W];
  int   rand_frame[H][W];
  int   checks;
  int   failures;
  int   out_count;
  int   cap[2];
  int   yr_mode;
  bit   stall_prev;
  logic [DW-1:0] stall_data;
  logic          stall_last;

  // Direct 3x3 reference for the centre at (r,c) of the current frame.
  function automatic int model(input int r, input int c, input int m);
    int cv, orth, diag, v;
    cv   = frame[r][c];
    orth = frame[r-1][c] + frame[r+1][c] + frame[r][c-1] + frame[r][c+1];
    diag = frame[r-1][c-1] + frame[r-1][c+1] + frame[r+1][c-1] + frame[r+1][c+1];
    case (m)
      1: begin
        v = 8 * cv - orth - diag;
        if (v < 0) v = -v;
        if (v > 255) v = 255;
      end
      2: v = (4 * cv + 2 * orth + diag) / 16;
      3: begin
        v = 5 * cv - orth;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
      end
      default: v = cv;
    endcase
    return v;
  endfunction

  task automatic fill(input int pat);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (pat)
          0: frame[r][c] = 100;
          1: frame[r][c] = (r == 1 && c == 1) ? 255 : 0;
          2: frame[r][c] = 8 * r + c;
          3: frame[r][c] = rand_frame[r][c];
          default: frame[r][c] = 255 - rand_frame[r][c];
        endcase
      end
    end
  endtask

  // Drives the first n_pix pixels of the current frame. mode_a is presented
  // before pixel index switch_idx and mode_b from then on; model_mode is the
  // kernel the frame is expected to use.
  task automatic drive_pixels(input int n_pix, input bit [1:0] mode_a,
                              input bit [1:0] mode_b, input int switch_idx,
                              input int model_mode, input bit use_sof,
                              input bit gaps);
    int   r, c;
    bit   acc;
    exp_t e;
    for (int i = 0; i < n_pix; i++) begin
      r = i / W;
      c = i % W;
      if (gaps && $urandom_range(0, 2) == 0) begin
        x_valid = 1'b0;
        x_sof   = 1'b0;
        x_data  = DW'($urandom);
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      x_valid = 1'b1;
      x_data  = DW'(frame[r][c]);
      x_sof   = use_sof && (i == 0);
      mode    = (i < switch_idx) ? mode_a : mode_b;
      if (r >= 2 && c >= 2) begin
        e.data = DW'(model(r - 1, c - 1, model_mode));
        e.last = (r == H - 1) && (c == W - 1);
        sb_q.push_back(e);
      end
      acc = 1'b0;
      for (int k = 0; k < 200 && !acc; k++) begin
        @(negedge clk);
        acc = x_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout pixel=%0d got=no_accept exp=accept", i);
      end
    end
    x_valid = 1'b0;
    x_sof   = 1'b0;
  endtask

  task automatic drain(input string name, input int exp_n);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || y_valid) && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (k >= 1000) begin
      failures++;
      $display("FAIL %s_drain got=queue_left_%0d exp=queue_empty", name, sb_q.size());
      sb_q.delete();
    end
    checks++;
    if (out_count != exp_n) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", name, out_count, exp_n);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (!y_valid || y_data !== stall_data || y_last !== stall_last) begin
            failures++;
            $display("FAIL stall_hold got=v%0d/d%0d/l%0d exp=v1/d%0d/l%0d",
                     y_valid, y_data, y_last, stall_data, stall_last);
          end
        end
        stall_prev = 1'b0;
        if (y_valid && !y_ready) begin
          checks++;
          if (x_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_x_ready got=%0d exp=0", x_ready);
          end
          stall_prev = 1'b1;
          stall_data = y_data;
          stall_last = y_last;
        end
        if (y_valid && y_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output got=%0d exp=none", y_data);
          end else begin
            e = sb_q.pop_front();
            if (y_data !== e.data || y_last !== e.last) begin
              failures++;
              $display("FAIL output_%0d got=%0d/last%0d exp=%0d/last%0d",
                       out_count, y_data, y_last, e.data, e.last);
            end
          end
          $display("out %0d data=%0d last=%0d", out_count, y_data, y_last);
          if (out_count < 2) cap[out_count] = int'(y_data);
          out_count++;
        end
      end
    end
  endtask

  task automatic yready_gen();
    forever begin
      @(posedge clk);
      #1;
      case (yr_mode)
        0:       y_ready = 1'b0;
        1:       y_ready = 1'b1;
        default: y_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    out_count  = 0;
    stall_prev = 1'b0;
    stall_data = '0;
    stall_last = 1'b0;
    cap[0]     = -1;
    cap[1]     = -1;
    yr_mode    = 0;
    reset      = 1'b1;
    mode       = 2'd0;
    x_data     = '0;
    x_valid    = 1'b0;
    x_sof      = 1'b0;
    y_ready    = 1'b0;

    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        rand_frame[r][c] = int'($urandom_range(0, 255));
      end
    end

    // {pattern, mode, stall, first output, second output}; -1 = model only
    vecs[0] = '{0, 2'd1, 1'b0, 0, 0};
    vecs[1] = '{0, 2'd2, 1'b0, 100, 100};
    vecs[2] = '{0, 2'd3, 1'b0, 100, 100};
    vecs[3] = '{0, 2'd0, 1'b0, 100, 100};
    vecs[4] = '{1, 2'd1, 1'b0, 255, 255};
    vecs[5] = '{1, 2'd3, 1'b0, 255, 0};
    vecs[6] = '{2, 2'd2, 1'b0, 9, 10};
    vecs[7] = '{3, 2'd3, 1'b0, -1, -1};
    vecs[8] = '{3, 2'd3, 1'b1, -1, -1};
    vecs[9] = '{3, 2'd1, 1'b1, -1, -1};

    fork
      monitor();
      yready_gen();
    join_none

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (x_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_x_ready got=%0d exp=1", x_ready);
    end
    checks++;
    if (y_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_y_valid got=%0d exp=0", y_valid);
    end
    checks++;
    if (y_data !== '0) begin
      failures++;
      $display("FAIL reset_y_data got=%0d exp=0", y_data);
    end
    checks++;
    if (y_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_y_last got=%0d exp=0", y_last);
    end

    reset = 1'b0;
    @(posedge clk);
    #1;
    yr_mode = 1;
    @(posedge clk);
    #1;

    for (int v = 0; v < NV; v++) begin
      fill(vecs[v].pat);
      yr_mode   = vecs[v].stall ? 2 : 1;
      out_count = 0;
      cap[0]    = -1;
      cap[1]    = -1;
      drive_pixels(W * H, vecs[v].md, vecs[v].md, 0, int'(vecs[v].md), 1'b1, vecs[v].stall);
      drain($sformatf("vec%0d", v), NOUT);
      if (vecs[v].exp0 >= 0) begin
        checks++;
        if (cap[0] != vecs[v].exp0) begin
          failures++;
          $display("FAIL vec%0d_first got=%0d exp=%0d", v, cap[0], vecs[v].exp0);
        end
        checks++;
        if (cap[1] != vecs[v].exp1) begin
          failures++;
          $display("FAIL vec%0d_second got=%0d exp=%0d", v, cap[1], vecs[v].exp1);
        end
      end
    end
    yr_mode = 1;

    // mode moves from blur to edge at pixel (2,3): this frame stays blur,
    // the following one runs as edge.
    fill(3);
    out_count = 0;
    drive_pixels(W * H, 2'd2, 2'd1, 2 * W + 3, 2, 1'b1, 1'b0);
    drain("modesw_blur", NOUT);
    out_count = 0;
    drive_pixels(W * H, 2'd1, 2'd1, 0, 1, 1'b1, 1'b0);
    drain("modesw_edge", NOUT);

    // Reset at pixel (2,5), then a clean frame presented without x_sof.
    fill(3);
    out_count = 0;
    drive_pixels(2 * W + 5, 2'd3, 2'd3, 0, 3, 1'b1, 1'b0);
    drain("abort_part", 3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    fill(4);
    out_count = 0;
    drive_pixels(W * H, 2'd3, 2'd3, 0, 3, 1'b0, 1'b0);
    drain("reset_clean", NOUT);

    // Frame broken at (2,5) and resynchronised by x_sof.
    fill(3);
    out_count = 0;
    drive_pixels(2 * W + 5, 2'd1, 2'd1, 0, 1, 1'b1, 1'b0);
    drain("sof_part", 3);
    fill(4);
    out_count = 0;
    drive_pixels(W * H, 2'd2, 2'd2, 0, 2, 1'b1, 1'b0);
    drain("sof_clean", NOUT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
